// File: rtl/pmem_responder_pkg.sv
// pmem_responder_pkg: FSM state encoding, default memory window and range check shared by the responder.
package pmem_responder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [31:0] DEF_PMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_PMEM_SIZE = 32'h0800_0000;
  // Wrapping subtract folds both below-base and above-top addresses into one compare.
  function automatic logic out_of_range(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [31:0] size);
    return (addr - base) >= size;
  endfunction
endpackage

// File: rtl/pmem_latency_ctr.sv
// pmem_latency_ctr: 4-bit loadable down-counter; o_done flags that the wait has run out.
module pmem_latency_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_dec,
  input  logic [3:0] i_val,
  output logic       o_done
);
  logic [3:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= i_load ? i_val : (i_dec ? r_cnt - 4'd1 : r_cnt);
  assign o_done = (r_cnt == 4'd0);
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: single-outstanding valid/ready memory endpoint with programmable wait before the access.
// Physical memory sits behind the pmem_* port; pmem_rdata must be valid in the cycle pmem_ren is high.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] PMEM_BASE = DEF_PMEM_BASE,
  parameter logic [31:0] PMEM_SIZE = DEF_PMEM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        pmem_ren,
  output logic        pmem_wen,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  output logic [7:0]  pmem_wmask,
  input  logic [31:0] pmem_rdata
);
  localparam logic [3:0] LAT = 4'(LATENCY);
  state_t      r_state, w_next;
  logic        r_ready, r_rsp_valid, r_err, r_wen;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_wmask;
  logic        w_accept, w_done, w_access, w_err, w_release, w_unused;
  assign w_unused  = ^req_wmask[7:4];
  assign w_accept  = req_valid & r_ready;
  assign w_access  = (r_state == S_WAIT) & w_done;
  assign w_release = (r_state == S_RESP) & rsp_ready;
  assign w_err     = out_of_range(r_addr, PMEM_BASE, PMEM_SIZE);
  pmem_latency_ctr u_ctr (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_accept),
    .i_dec  ((r_state == S_WAIT) & ~w_done),
    .i_val  (LAT),
    .o_done (w_done)
  );
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = S_WAIT;
    if (w_access) w_next = S_RESP;
    if (w_release) w_next = S_IDLE;
  end
  // Memory strobes fire only in the single cycle whose closing edge enters RESP.
  assign pmem_ren   = w_access & ~r_wen & ~w_err;
  assign pmem_wen   = w_access & r_wen & ~w_err & (|r_wmask);
  assign pmem_addr  = {r_addr[31:2], 2'b00};
  assign pmem_wdata = r_wdata;
  assign pmem_wmask = {4'b0000, r_wmask};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      if (w_accept) begin
        r_wen   <= req_wen;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wmask <= req_wmask[3:0];
      end
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rdata     <= (r_wen | w_err) ? 32'd0 : pmem_rdata;
        r_err       <= w_err;
      end else if (w_release) r_rsp_valid <= 1'b0;
    end
  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: directed checks of two responders (LATENCY 2 and 0) sharing a small memory model.
module tb_pmem_responder;
  logic        clk = 0, reset = 0, sel = 0;
  logic        req_valid = 0, req_wen = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [7:0]  req_wmask = 0;
  logic        rdy0, rdy1, rv0, rv1, er0, er1, ren0, ren1, wen0, wen1;
  logic [31:0] rd0, rd1, pa0, pa1, pw0, pw1;
  logic [7:0]  pm0, pm1;
  logic [31:0] mem [16];
  int          n_rd = 0, n_wr = 0, checks = 0, errors = 0, lat;
  logic        ready, rvalid, rerr;
  logic [31:0] rdata;
  always #5 clk = ~clk;
  pmem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy0), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rv0),
    .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(er0), .pmem_ren(ren0), .pmem_wen(wen0),
    .pmem_addr(pa0), .pmem_wdata(pw0), .pmem_wmask(pm0), .pmem_rdata(mem[pa0[5:2]]));
  pmem_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy1), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rv1),
    .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(er1), .pmem_ren(ren1), .pmem_wen(wen1),
    .pmem_addr(pa1), .pmem_wdata(pw1), .pmem_wmask(pm1), .pmem_rdata(mem[pa1[5:2]]));
  assign ready  = sel ? rdy1 : rdy0;
  assign rvalid = sel ? rv1 : rv0;
  assign rdata  = sel ? rd1 : rd0;
  assign rerr   = sel ? er1 : er0;
  always @(posedge clk) begin
    n_rd += int'(ren0) + int'(ren1);
    n_wr += int'(wen0) + int'(wen1);
    for (int b = 0; b < 4; b++) begin
      if (wen0 && pm0[b]) mem[pa0[5:2]][b*8 +: 8] <= pw0[b*8 +: 8];
      if (wen1 && pm1[b]) mem[pa1[5:2]][b*8 +: 8] <= pw1[b*8 +: 8];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
    req_valid = 1; req_wen = w; req_addr = a; req_wdata = d; req_wmask = m;
    cyc();
    req_valid = 0; req_wen = ~w; req_addr = 32'hDEAD_BEE0; req_wdata = 32'hFFFF_FFFF; req_wmask = 8'hFF;
  endtask
  task automatic wait_rsp();
    lat = 0;
    while (!rvalid && lat < 20) begin
      cyc();
      lat++;
    end
  endtask
  task automatic release_rsp();
    rsp_ready = 1;
    cyc();
    rsp_ready = 0;
    chk("rsp_valid_after_hs", 32'(rvalid), 0);
    chk("req_ready_after_hs", 32'(ready), 1);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h0010_0073; mem[1] = 32'h1122_3344; mem[4] = 32'hAABB_CCDD; mem[15] = 32'h5A5A_5A5A;
    #12;
    chk("rst_req_ready", 32'(ready), 0);
    chk("rst_rsp_valid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(rerr), 0);
    reset = 1;
    #1;
    chk("ready_before_edge", 32'(ready), 0);
    cyc();
    chk("ready_after_release", 32'(ready), 1);
    issue(0, 32'h8000_0000, 0, 0);
    chk("ready_in_wait", 32'(ready), 0);
    wait_rsp();
    chk("l2_latency", lat, 3);
    chk("l2_rdata", rdata, 32'h0010_0073);
    chk("l2_err", 32'(rerr), 0);
    chk("l2_reads", n_rd, 1);
    release_rsp();
    issue(1, 32'h8000_0010, 32'h1234_5678, 8'hF1);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(rvalid), 1);
      chk("hold_rdata", rdata, 0);
      chk("hold_err", 32'(rerr), 0);
      chk("hold_ready", 32'(ready), 0);
      cyc();
    end
    chk("one_write", n_wr, 1);
    release_rsp();
    issue(0, 32'h8000_0013, 0, 0);
    wait_rsp();
    chk("merged_rdata", rdata, 32'hAABB_CC78);
    release_rsp();
    issue(0, 32'h8800_0000, 0, 0);
    wait_rsp();
    chk("oor_hi_err", 32'(rerr), 1);
    chk("oor_hi_rdata", rdata, 0);
    chk("oor_hi_no_read", n_rd, 2);
    release_rsp();
    issue(1, 32'h0000_0000, 32'hCAFE_F00D, 8'h0F);
    wait_rsp();
    chk("oor_lo_err", 32'(rerr), 1);
    chk("oor_lo_no_write", n_wr, 1);
    release_rsp();
    issue(0, 32'h87FF_FFFC, 0, 0);
    wait_rsp();
    chk("top_word_err", 32'(rerr), 0);
    chk("top_word_rdata", rdata, 32'h5A5A_5A5A);
    release_rsp();
    issue(0, 32'h7FFF_FFFC, 0, 0);
    wait_rsp();
    chk("below_base_err", 32'(rerr), 1);
    release_rsp();
    issue(1, 32'h8000_0004, 32'h0, 8'h00);
    wait_rsp();
    chk("mask0_err", 32'(rerr), 0);
    chk("mask0_no_write", n_wr, 1);
    chk("mask0_mem", mem[1], 32'h1122_3344);
    release_rsp();
    sel = 1;
    #1;
    chk("l0_ready", 32'(ready), 1);
    issue(0, 32'h8000_0006, 0, 0);
    wait_rsp();
    chk("l0_latency", lat, 1);
    chk("l0_rdata", rdata, 32'h1122_3344);
    release_rsp();
    sel = 0;
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h0F);
    cyc();
    #3;
    reset = 0;
    #1;
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_valid", 32'(rvalid), 0);
    cyc();
    cyc();
    reset = 1;
    cyc();
    cyc();
    cyc();
    chk("dropped_mem", mem[0], 32'h0010_0073);
    chk("dropped_writes", n_wr, 1);
    chk("ready_after_rst", 32'(ready), 1);
    chk("no_rsp_after_rst", 32'(rvalid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
